dma_engine: RTL and testbench

DMA_ENGINE -- requirements
Module: dma_engine

---
 rtl/dma_engine.sv | 192 +++++++++++++++++++
 tb/tb_dma_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_engine.sv
// Multi-channel memory-to-memory DMA that halts the CPU and moves len bytes as
// alternating read/write bus cycles. Lowest-index pending channel wins.
module dma_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int REG_WIDTH  = 8,
    parameter int CHANNELS   = 2,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                           phi2,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            req,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] src_addr,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] dst_addr,
    input  logic [CHANNELS*LEN_WIDTH-1:0]  len,
    input  logic [CHANNELS-1:0]            dst_fixed,
    input  logic                           cpu_rw_n,
    input  logic [REG_WIDTH-1:0]           d_in,
    output logic                           rdy,
    output logic                           bus_en,
    output logic [ADDR_WIDTH-1:0]          A,
    output logic [REG_WIDTH-1:0]           d_out,
    output logic                           R_W_n,
    output logic [CHANNELS-1:0]            done,
    output logic                           busy,
    output logic [2:0]                     active_ch
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [CHANNELS-1:0]     pending_q, pending_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d;
    logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    fixed_q, fixed_d;
    logic [REG_WIDTH-1:0]    data_q, data_d;
    logic [2:0]              ch_q, ch_d;

    logic                    sel_vld;
    logic [2:0]              sel_ch;
    logic [ADDR_WIDTH-1:0]   sel_src;
    logic [ADDR_WIDTH-1:0]   sel_dst;
    logic [LEN_WIDTH-1:0]    sel_len;
    logic                    sel_fixed;
    logic                    take;

    // Scan downwards so the lowest-index pending channel is the last assignment.
    always_comb begin
        sel_vld   = 1'b0;
        sel_ch    = '0;
        sel_src   = '0;
        sel_dst   = '0;
        sel_len   = '0;
        sel_fixed = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_vld   = 1'b1;
                sel_ch    = 3'(i);
                sel_src   = src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_dst   = dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len   = len[i*LEN_WIDTH +: LEN_WIDTH];
                sel_fixed = dst_fixed[i];
            end
        end
    end

    assign take = (state_q == S_IDLE) && sel_vld;

    // State register
    always_ff @(posedge phi2) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    state_d = (sel_len == '0) ? S_DONE : S_HALT;
                end
            end
            S_HALT: begin
                // A CPU write cycle cannot be stretched, so only leave on a read.
                if (cpu_rw_n) begin
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = (cnt_q == LEN_WIDTH'(1)) ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state
    always_comb begin
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        fixed_d = fixed_q;
        data_d  = data_q;
        ch_d    = ch_q;
        for (int i = 0; i < CHANNELS; i++) begin
            pending_d[i] = (pending_q[i] && !(take && (sel_ch == 3'(i)))) || req[i];
        end
        case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    src_d   = sel_src;
                    dst_d   = sel_dst;
                    cnt_d   = sel_len;
                    fixed_d = sel_fixed;
                    ch_d    = sel_ch;
                end
            end
            S_READ: data_d = d_in;
            S_WRITE: begin
                src_d = src_q + ADDR_WIDTH'(1);
                if (!fixed_q) begin
                    dst_d = dst_q + ADDR_WIDTH'(1);
                end
                cnt_d = cnt_q - LEN_WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge phi2) begin
        if (reset) begin
            pending_q <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            fixed_q   <= 1'b0;
            data_q    <= '0;
            ch_q      <= '0;
        end else begin
            pending_q <= pending_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            fixed_q   <= fixed_d;
            data_q    <= data_d;
            ch_q      <= ch_d;
        end
    end

    // Output logic: idle bus is parked at A=0, d_out=0, read.
    always_comb begin
        rdy    = 1'b1;
        bus_en = 1'b0;
        A      = '0;
        d_out  = '0;
        R_W_n  = 1'b1;
        case (state_q)
            S_HALT, S_ALIGN: rdy = 1'b0;
            S_READ: begin
                rdy    = 1'b0;
                bus_en = 1'b1;
                A      = src_q;
            end
            S_WRITE: begin
                rdy    = 1'b0;
                bus_en = 1'b1;
                A      = dst_q;
                d_out  = data_q;
                R_W_n  = 1'b0;
            end
            default: ;
        endcase
        for (int i = 0; i < CHANNELS; i++) begin
            done[i] = (state_q == S_DONE) && (ch_q == 3'(i));
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign active_ch = ch_q;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: table of single transfers plus hand-written
// sequences for priority, write stall, mid-transfer reset and re-request.
module tb_dma_engine;

    logic        phi2;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [17:0] len;
    logic [1:0]  dst_fixed;
    logic        cpu_rw_n;
    logic [7:0]  d_in;
    logic        rdy;
    logic        bus_en;
    logic [15:0] A;
    logic [7:0]  d_out;
    logic        R_W_n;
    logic [1:0]  done;
    logic        busy;
    logic [2:0]  active_ch;

    dma_engine #(.ADDR_WIDTH(16), .REG_WIDTH(8), .CHANNELS(2), .LEN_WIDTH(9)) dut (
        .phi2(phi2), .reset(reset), .req(req), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .dst_fixed(dst_fixed), .cpu_rw_n(cpu_rw_n), .d_in(d_in),
        .rdy(rdy), .bus_en(bus_en), .A(A), .d_out(d_out), .R_W_n(R_W_n),
        .done(done), .busy(busy), .active_ch(active_ch)
    );

    initial begin
        phi2 = 1'b0;
        forever #5 phi2 = ~phi2;
    end

    logic [7:0] mem [0:65535];
    assign d_in = (bus_en && R_W_n) ? mem[A] : 8'h00;

    typedef struct {
        logic        rw;
        logic [15:0] a;
        logic [7:0]  d;
    } beat_t;

    beat_t      log_q[$];
    logic [1:0] done_q[$];
    int         rdy_low;
    int         cyc;
    int         n_checks;
    int         n_fail;

    always @(negedge phi2) begin
        cyc++;
        if (!reset) begin
            if (!rdy) rdy_low++;
            if (bus_en) log_q.push_back('{R_W_n, A, d_out});
            if (done != 2'b00) done_q.push_back(done);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic clear_logs();
        @(posedge phi2);
        log_q.delete();
        done_q.delete();
        rdy_low = 0;
    endtask

    task automatic set_ch(input int ch, input logic [15:0] s, input logic [15:0] d,
                          input logic [8:0] n, input logic f);
        src_addr[ch*16 +: 16] = s;
        dst_addr[ch*16 +: 16] = d;
        len[ch*9 +: 9]        = n;
        dst_fixed[ch]         = f;
    endtask

    task automatic pulse_req(input logic [1:0] m);
        @(negedge phi2);
        req = m;
        @(negedge phi2);
        req = 2'b00;
    endtask

    task automatic wait_done(input int n, input string name);
        int t;
        t = 0;
        while (done_q.size() < n && t < 300) begin
            @(negedge phi2);
            t++;
        end
        if (done_q.size() < n) timeout_fail(name);
        repeat (3) @(negedge phi2);
    endtask

    typedef struct {
        int          ch;
        logic [15:0] src;
        logic [15:0] dst;
        logic [8:0]  n;
        logic        fixed;
        int          exp_rdy_low;
        logic [15:0] exp_last_rd;
        logic [15:0] exp_last_wr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rdy_low   = 0;
        cyc       = 0;
        reset     = 1'b1;
        req       = 2'b00;
        src_addr  = '0;
        dst_addr  = '0;
        len       = '0;
        dst_fixed = '0;
        cpu_rw_n  = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        mem[16'h0200] = 8'hAA; mem[16'h0201] = 8'hBB; mem[16'h0202] = 8'hCC;
        mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22; mem[16'h0300] = 8'h5A;

        //           ch  src       dst       len fixed rdylow last_rd   last_wr
        vecs[0] = '{0, 16'h0200, 16'h2004, 9'd3, 1'b1, 8,  16'h0202, 16'h2004};
        vecs[1] = '{1, 16'hFFFF, 16'h0010, 9'd2, 1'b0, 6,  16'h0000, 16'h0011};
        vecs[2] = '{1, 16'h4000, 16'h5000, 9'd0, 1'b0, 0,  16'h0000, 16'h0000};
        vecs[3] = '{0, 16'h0300, 16'h0400, 9'd1, 1'b0, 4,  16'h0300, 16'h0400};
        vecs[4] = '{1, 16'h1000, 16'h8000, 9'd5, 1'b0, 12, 16'h1004, 16'h8004};

        // Reset state, with a req pulse coincident with reset that must be dropped
        set_ch(0, 16'h0100, 16'h0180, 9'd2, 1'b0);
        set_ch(1, 16'h0110, 16'h0190, 9'd2, 1'b0);
        @(negedge phi2); req = 2'b11;
        repeat (2) @(negedge phi2);
        reset = 1'b0;
        req   = 2'b00;
        check("reset rdy", 32'(rdy), 32'd1);
        check("reset bus_en", 32'(bus_en), 32'd0);
        check("reset A", 32'(A), 32'd0);
        check("reset d_out", 32'(d_out), 32'd0);
        check("reset R_W_n", 32'(R_W_n), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset active_ch", 32'(active_ch), 32'd0);
        repeat (6) @(negedge phi2);
        check("req-in-reset busy", 32'(busy), 32'd0);
        check("req-in-reset bus beats", 32'(log_q.size()), 32'd0);

        // Table of single transfers
        for (int v = 0; v < 5; v++) begin
            set_ch(vecs[v].ch, vecs[v].src, vecs[v].dst, vecs[v].n, vecs[v].fixed);
            clear_logs();
            pulse_req(2'(1 << vecs[v].ch));
            wait_done(1, $sformatf("vec%0d done", v));
            check($sformatf("vec%0d rdy low cycles", v), 32'(rdy_low), 32'(vecs[v].exp_rdy_low));
            check($sformatf("vec%0d bus beats", v), 32'(log_q.size()), 32'(2 * vecs[v].n));
            check($sformatf("vec%0d done pulses", v), 32'(done_q.size()), 32'd1);
            if (done_q.size() >= 1)
                check($sformatf("vec%0d done mask", v), 32'(done_q[0]), 32'(1 << vecs[v].ch));
            check($sformatf("vec%0d active_ch", v), 32'(active_ch), 32'(vecs[v].ch));
            if (log_q.size() == 2 * vecs[v].n) begin
                for (int k = 0; k < int'(vecs[v].n); k++) begin
                    logic [15:0] ra, wa;
                    ra = vecs[v].src + 16'(k);
                    wa = vecs[v].fixed ? vecs[v].dst : vecs[v].dst + 16'(k);
                    check($sformatf("vec%0d rd%0d rw", v, k), 32'(log_q[2*k].rw), 32'd1);
                    check($sformatf("vec%0d rd%0d addr", v, k), 32'(log_q[2*k].a), 32'(ra));
                    check($sformatf("vec%0d rd%0d d_out", v, k), 32'(log_q[2*k].d), 32'd0);
                    check($sformatf("vec%0d wr%0d rw", v, k), 32'(log_q[2*k+1].rw), 32'd0);
                    check($sformatf("vec%0d wr%0d addr", v, k), 32'(log_q[2*k+1].a), 32'(wa));
                    check($sformatf("vec%0d wr%0d data", v, k), 32'(log_q[2*k+1].d), 32'(mem[ra]));
                end
                if (vecs[v].n > 0) begin
                    check($sformatf("vec%0d last rd", v), 32'(log_q[2*vecs[v].n-2].a), 32'(vecs[v].exp_last_rd));
                    check($sformatf("vec%0d last wr", v), 32'(log_q[2*vecs[v].n-1].a), 32'(vecs[v].exp_last_wr));
                end
            end
        end

        // Priority: both channels requested in the same cycle
        set_ch(0, 16'h0500, 16'h0600, 9'd2, 1'b0);
        set_ch(1, 16'h0700, 16'h0800, 9'd1, 1'b1);
        clear_logs();
        pulse_req(2'b11);
        wait_done(2, "prio done");
        check("prio done count", 32'(done_q.size()), 32'd2);
        if (done_q.size() >= 2) begin
            check("prio first done", 32'(done_q[0]), 32'h1);
            check("prio second done", 32'(done_q[1]), 32'h2);
        end
        check("prio bus beats", 32'(log_q.size()), 32'd6);
        if (log_q.size() == 6) begin
            check("prio ch0 first rd", 32'(log_q[0].a), 32'h0500);
            check("prio ch1 rd", 32'(log_q[4].a), 32'h0700);
            check("prio ch1 wr", 32'(log_q[5].a), 32'h0800);
        end
        check("prio rdy low", 32'(rdy_low), 32'd10);

        // Write stall: CPU writing during the first HALT cycles
        begin
            int t;
            set_ch(0, 16'h0D00, 16'h0E00, 9'd1, 1'b0);
            clear_logs();
            cpu_rw_n = 1'b0;
            pulse_req(2'b01);
            t = 0;
            while (rdy && t < 20) begin
                @(negedge phi2);
                t++;
            end
            if (rdy) timeout_fail("stall halt entry");
            check("stall halt1 bus_en", 32'(bus_en), 32'd0);
            @(negedge phi2);
            check("stall halt2 rdy", 32'(rdy), 32'd0);
            check("stall halt2 bus_en", 32'(bus_en), 32'd0);
            @(negedge phi2);
            check("stall halt3 bus_en", 32'(bus_en), 32'd0);
            cpu_rw_n = 1'b1;
            @(negedge phi2);
            check("stall align rdy", 32'(rdy), 32'd0);
            check("stall align bus_en", 32'(bus_en), 32'd0);
            @(negedge phi2);
            check("stall read bus_en", 32'(bus_en), 32'd1);
            check("stall read A", 32'(A), 32'h0D00);
            wait_done(1, "stall done");
            check("stall rdy low", 32'(rdy_low), 32'd6);
        end

        // Reset in the second WRITE of a len=4 transfer
        begin
            int t, wr;
            set_ch(0, 16'h0900, 16'h0A00, 9'd4, 1'b0);
            clear_logs();
            pulse_req(2'b01);
            t = 0;
            wr = 0;
            while (wr < 2 && t < 40) begin
                @(negedge phi2);
                if (bus_en && !R_W_n) wr++;
                t++;
            end
            if (wr < 2) timeout_fail("midreset second write");
            reset = 1'b1;
            @(negedge phi2);
            reset = 1'b0;
            check("midreset rdy", 32'(rdy), 32'd1);
            check("midreset bus_en", 32'(bus_en), 32'd0);
            check("midreset busy", 32'(busy), 32'd0);
            check("midreset done", 32'(done), 32'd0);
            log_q.delete();
            repeat (10) @(negedge phi2);
            check("midreset later beats", 32'(log_q.size()), 32'd0);
            check("midreset done pulses", 32'(done_q.size()), 32'd0);
            check("midreset later busy", 32'(busy), 32'd0);
        end

        // Re-request of ch0 while its own transfer is running
        begin
            int t;
            set_ch(0, 16'h0B00, 16'h0C00, 9'd2, 1'b0);
            clear_logs();
            pulse_req(2'b01);
            t = 0;
            while (rdy && t < 20) begin
                @(negedge phi2);
                t++;
            end
            if (rdy) timeout_fail("rereq first start");
            req = 2'b01;
            @(negedge phi2);
            req = 2'b00;
            wait_done(2, "rereq done");
            check("rereq done count", 32'(done_q.size()), 32'd2);
            if (done_q.size() >= 2) check("rereq second mask", 32'(done_q[1]), 32'h1);
            check("rereq bus beats", 32'(log_q.size()), 32'd8);
            if (log_q.size() == 8) check("rereq second rd", 32'(log_q[4].a), 32'h0B00);
            check("rereq rdy low", 32'(rdy_low), 32'd12);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
